// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   mem_size_e  : access size codes, identical to the decoder's mem_size field
//   lsu_state_e : FSM state encoding of the load/store unit
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // True when an access of the given size cannot be issued at this byte offset.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_HALF: bad = addr_lo[0];
            MEM_WORD: bad = (addr_lo != 2'b00);
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide request/acknowledge data bus with byte enables.
//   master : bus_req, bus_we, bus_addr, bus_be, bus_wdata out; bus_ack, bus_rdata in
//   slave  : mirror image of master
// bus_rdata is valid in the same cycle as bus_ack for reads.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for sub-word accesses.
//   addr_lo, size, unsigned_value : access descriptor
//   wdata      : right-justified store data
//   rdata      : raw word read from the bus
//   be         : byte enables for the addressed lanes
//   wdata_rep  : store data replicated into every lane of its size
//   rdata_ext  : addressed byte/half moved to bit 0 and sign/zero extended
//   misaligned : access crosses its natural alignment
// Also used by the fetch path, so it carries no state.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        unsigned_value,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rbyte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel   = rbyte[addr_lo];
    assign half_sel   = addr_lo[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};
    assign misaligned = is_misaligned(size, addr_lo);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            MEM_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_sel[7] & ~unsigned_value}}, byte_sel};
            end
            MEM_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_sel[15] & ~unsigned_value}}, half_sel};
            end
            MEM_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage for decoded loads and stores.
//   clk, reset          : core clock, synchronous active-high reset
//   start               : issue strobe, only looked at while busy==0
//   mem_r, mem_w        : load / store request (exactly one must be set)
//   mem_size            : byte / half / word / illegal
//   unsigned_value      : zero-extend sub-word loads
//   addr, wdata         : effective byte address and right-justified store data
//   rd_sel_in           : load destination register
//   busy, done, err     : status; done is a one-cycle completion pulse, err valid with it
//   rd_w, rd_sel, rd_data : register write-back (rd_w pulses for successful loads only)
//   bus                 : request/acknowledge data bus (master side)
// Flow: IDLE -> REQ -> RESP -> IDLE; misaligned or illegal-size accesses go IDLE -> RESP.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [1:0]  mem_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_sel_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_w,
    output logic [4:0]  rd_sel,
    output logic [31:0] rd_data,
    load_store_unit_if.master bus
);

    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 1;

    lsu_state_e  state_reg;
    logic [31:0] count_reg;
    logic        is_load_reg;
    logic        err_pend_reg;
    logic [1:0]  addr_lo_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;

    logic [1:0]  align_addr_lo;
    logic [1:0]  align_size;
    logic        align_unsigned;
    logic [3:0]  be_next;
    logic [31:0] wdata_rep_next;
    logic [31:0] rdata_ext_next;
    logic        misaligned_next;
    logic        accept;

    // In IDLE the aligner sees the live request (to build the bus cycle);
    // afterwards it sees the captured descriptor (to extract the load data).
    assign align_addr_lo  = (state_reg == ST_IDLE) ? addr[1:0]      : addr_lo_reg;
    assign align_size     = (state_reg == ST_IDLE) ? mem_size       : size_reg;
    assign align_unsigned = (state_reg == ST_IDLE) ? unsigned_value : unsigned_reg;

    lsu_lane_align u_align (
        .addr_lo        (align_addr_lo),
        .size           (align_size),
        .unsigned_value (align_unsigned),
        .wdata          (wdata),
        .rdata          (bus.bus_rdata),
        .be             (be_next),
        .wdata_rep      (wdata_rep_next),
        .rdata_ext      (rdata_ext_next),
        .misaligned     (misaligned_next)
    );

    // Loads and stores together (or neither) are treated as a no-op.
    assign accept = start & (mem_r ^ mem_w);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            is_load_reg   <= 1'b0;
            err_pend_reg  <= 1'b0;
            addr_lo_reg   <= 2'b00;
            size_reg      <= 2'b00;
            unsigned_reg  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rd_w          <= 1'b0;
            rd_sel        <= '0;
            rd_data       <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= '0;
        end else begin
            done <= 1'b0;
            rd_w <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        rd_sel       <= rd_sel_in;
                        is_load_reg  <= mem_r;
                        addr_lo_reg  <= addr[1:0];
                        size_reg     <= mem_size;
                        unsigned_reg <= unsigned_value;
                        if (misaligned_next || (mem_size == MEM_ILLEGAL)) begin
                            err_pend_reg <= 1'b1;
                            state_reg    <= ST_RESP;
                        end else begin
                            err_pend_reg  <= 1'b0;
                            count_reg     <= '0;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_w;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_be    <= be_next;
                            bus.bus_wdata <= wdata_rep_next;
                            state_reg     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so an ack on the last allowed cycle succeeds.
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (is_load_reg) begin
                            rd_data <= rdata_ext_next;
                        end
                        state_reg <= ST_RESP;
                    end else if (TIMEOUT_EN && (count_reg == TIMEOUT_LAST)) begin
                        bus.bus_req  <= 1'b0;
                        err_pend_reg <= 1'b1;
                        state_reg    <= ST_RESP;
                    end else begin
                        count_reg <= count_reg + 32'd1;
                    end
                end
                ST_RESP: begin
                    done      <= 1'b1;
                    err       <= err_pend_reg;
                    rd_w      <= is_load_reg & ~err_pend_reg;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_r;
    logic        mem_w;
    logic [1:0]  mem_size;
    logic        unsigned_value;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_sel_in;
    logic        busy;
    logic        done;
    logic        err;
    logic        rd_w;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    // Reference state: last successfully loaded value and last captured destination.
    logic [31:0] exp_rd_data;
    logic [4:0]  exp_rd_sel;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mem_r          (mem_r),
        .mem_w          (mem_w),
        .mem_size       (mem_size),
        .unsigned_value (unsigned_value),
        .addr           (addr),
        .wdata          (wdata),
        .rd_sel_in      (rd_sel_in),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rd_w           (rd_w),
        .rd_sel         (rd_sel),
        .rd_data        (rd_data),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected-value helpers written straight from the lane rules.
    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] a, input logic [31:0] rdw);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rdw >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (rdw >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = rdw;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd0) return 4'(1 << a[1:0]);
        if (size == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // One complete transaction; the bench plays the slave, acking after 'waits'
    // cycles of bus_req (waits >= TO means the slave never answers).
    task automatic run_op(input logic is_load, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rs,
                          input int waits, input logic [31:0] rdw);
        logic bad;
        logic ok;
        bad = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00);
        ok  = !bad && (waits < TO);

        mem_r = is_load; mem_w = !is_load; mem_size = size; unsigned_value = uns;
        addr = a; wdata = wd; rd_sel_in = rs; start = 1'b1;
        tick();
        start = 1'b0;
        mem_r = $urandom_range(0, 1); mem_w = $urandom_range(0, 1);
        addr = $urandom; wdata = $urandom; rd_sel_in = 5'($urandom);
        exp_rd_sel = rs;

        check_eq("busy_issue", 32'(busy), 32'd1);
        check_eq("done_issue", 32'(done), 32'd0);
        check_eq("err_clear", 32'(err), 32'd0);

        if (bad) begin
            check_eq("noreq_err", 32'(bus_if.bus_req), 32'd0);
            tick();
            check_eq("noreq_err2", 32'(bus_if.bus_req), 32'd0);
        end else begin
            for (int n = 0; n < TO; n++) begin
                check_eq("req_hi", 32'(bus_if.bus_req), 32'd1);
                check_eq("we", 32'(bus_if.bus_we), 32'(!is_load));
                check_eq("baddr", bus_if.bus_addr, a & 32'hFFFFFFFC);
                check_eq("be", 32'(bus_if.bus_be), 32'(model_be(size, a)));
                if (!is_load) check_eq("bwdata", bus_if.bus_wdata, model_wdata(size, wd));
                check_eq("done_wait", 32'(done), 32'd0);
                if (n == waits) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = rdw;
                    tick();
                    bus_if.bus_ack = 1'b0;
                    bus_if.bus_rdata = $urandom;
                    break;
                end
                tick();
            end
            check_eq("req_drop", 32'(bus_if.bus_req), 32'd0);
            check_eq("done_resp", 32'(done), 32'd0);
            tick();
        end

        if (ok && is_load) exp_rd_data = model_load(size, uns, a, rdw);
        check_eq("done", 32'(done), 32'd1);
        check_eq("err", 32'(err), 32'(!ok));
        check_eq("rd_w", 32'(rd_w), 32'(ok && is_load));
        check_eq("rd_data", rd_data, exp_rd_data);
        check_eq("rd_sel", 32'(rd_sel), 32'(exp_rd_sel));
        check_eq("busy_done", 32'(busy), 32'd0);
        $display("op ld=%0d size=%0d uns=%0d addr=%h wdata=%h waits=%0d rdata=%h -> err=%0d rd_w=%0d rd_data=%h",
                 is_load, size, uns, a, wd, waits, rdw, err, rd_w, rd_data);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_r = 1'b0; mem_w = 1'b0; mem_size = 2'b00;
        unsigned_value = 1'b0; addr = '0; wdata = '0; rd_sel_in = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        exp_rd_data = '0; exp_rd_sel = '0;
        tick(); tick();

        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rd_w", 32'(rd_w), 32'd0);
        check_eq("rst_req", 32'(bus_if.bus_req), 32'd0);
        check_eq("rst_we", 32'(bus_if.bus_we), 32'd0);
        check_eq("rst_be", 32'(bus_if.bus_be), 32'd0);
        check_eq("rst_addr", bus_if.bus_addr, 32'd0);
        check_eq("rst_wdata", bus_if.bus_wdata, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        check_eq("rst_rd_sel", 32'(rd_sel), 32'd0);
        reset = 1'b0;
        tick();

        // Directed cases.
        run_op(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 0, 32'h8000_0000);
        check_eq("lb_value", rd_data, 32'hFFFF_FF80);
        run_op(1'b1, 2'd1, 1'b1, 32'h102, 32'h0, 5'd9, 0, 32'h8001_0000);
        check_eq("lhu_value", rd_data, 32'h0000_8001);
        run_op(1'b0, 2'd0, 1'b0, 32'h201, 32'h1234_5678, 5'd3, 0, 32'h0);
        run_op(1'b1, 2'd2, 1'b0, 32'h102, 32'h0, 5'd4, 0, 32'h0);
        run_op(1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'h0);
        run_op(1'b1, 2'd2, 1'b0, 32'h300, 32'h0, 5'd6, TO, 32'h0);
        run_op(1'b1, 2'd2, 1'b0, 32'h304, 32'h0, 5'd8, TO - 1, 32'hCAFE_F00D);

        // mem_r == mem_w: ignored.
        mem_r = 1'b1; mem_w = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("noop_busy", 32'(busy), 32'd0);
        check_eq("noop_req", 32'(bus_if.bus_req), 32'd0);
        tick();
        check_eq("noop_done", 32'(done), 32'd0);

        // Reset while a request is outstanding.
        mem_r = 1'b1; mem_w = 1'b0; mem_size = 2'd2; addr = 32'h400; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("mid_req", 32'(bus_if.bus_req), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_rd_data = '0;
        tick();
        check_eq("mid_rst_done2", 32'(done), 32'd0);
        check_eq("mid_rst_rd_data", rd_data, 32'd0);

        // Randomized traffic, issued back-to-back.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          w;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            w = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   5'($urandom), w, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
